reg_file_mp: RTL

Parametrised multi-port register file for the RISC-V datapath, the successor to the two-read/one-write file used by the single-cycle core. It provides `NRD` combinational read ports and `NWR` clocked write ports. It also offers optional write-to-read bypass, a hardwired zero register, and a sequenced clear engine that zeroes the array one entry per cycle on request. It sits between decode (read addresses), writeback (write ports) and the core control FSM (clear handshake).

---
 rtl/reg_file_pkg.sv | 6 +
 rtl/rf_clear_seq.sv | 63 ++++++
 rtl/reg_file_mp.sv | 72 +++++++
 3 files changed

// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the multi-port register file.
package reg_file_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, DONE} rf_state_t;
  localparam int RF_XLEN_DEFAULT  = 32;
  localparam int RF_NREGS_DEFAULT = 32;
endpackage

// File: rtl/rf_clear_seq.sv
// Clear sequencer: walks the array one entry per cycle and signals busy/done.
module rf_clear_seq
  import reg_file_pkg::*;
#(
  parameter int NREGS = RF_NREGS_DEFAULT,
  parameter int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr_req,
  output logic          idle,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr,
  output logic          clr_busy,
  output logic          clr_done
);
  rf_state_t     state, state_nx;
  logic [AW-1:0] ptr, ptr_nx;
  logic          last;

  assign last     = (ptr == AW'(NREGS - 1));
  assign idle     = (state == IDLE);
  assign clr_we   = (state == CLEAR);
  assign clr_addr = ptr;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    unique case (state)
      IDLE: if (clr_req) begin
        state_nx = CLEAR;
        ptr_nx   = '0;
      end
      CLEAR: begin
        // pointer parks on the last entry rather than wrapping
        if (last) state_nx = DONE;
        else      ptr_nx   = ptr + AW'(1);
      end
      DONE: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
      default: begin
        state_nx = IDLE;
        ptr_nx   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      ptr      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      clr_busy <= (state_nx == CLEAR);
      clr_done <= (state_nx == DONE);
    end
  end
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: NWR clocked writes, NRD combinational reads,
// optional same-cycle bypass, hardwired x0 and a sequenced clear.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter  int XLEN     = RF_XLEN_DEFAULT,
  parameter  int NREGS    = RF_NREGS_DEFAULT,
  parameter  int NRD      = 2,
  parameter  int NWR      = 2,
  parameter  int BYPASS   = 1,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NWR-1:0]            we,
  input  logic [NWR-1:0][AW-1:0]    waddr,
  input  logic [NWR-1:0][XLEN-1:0]  wdata,
  input  logic [NRD-1:0][AW-1:0]    raddr,
  output logic [NRD-1:0][XLEN-1:0]  rdata,
  input  logic                      clr_req,
  output logic                      clr_busy,
  output logic                      clr_done
);
  logic [XLEN-1:0] mem [NREGS];
  logic            idle, clr_we;
  logic [AW-1:0]   clr_addr;
  logic [NWR-1:0]  wacc;

  rf_clear_seq #(.NREGS(NREGS), .AW(AW)) u_clr (
    .clk      (clk),
    .reset    (reset),
    .clr_req  (clr_req),
    .idle     (idle),
    .clr_we   (clr_we),
    .clr_addr (clr_addr),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  // accepted writes: only in IDLE, in range, and never to x0 when hardwired
  always_comb begin
    wacc = '0;
    for (int p = 0; p < NWR; p++)
      wacc[p] = we[p] && idle && (int'(waddr[p]) < NREGS) &&
                !((ZERO_REG != 0) && (waddr[p] == '0));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      // ascending order so the highest-index port wins a conflict
      for (int p = 0; p < NWR; p++)
        if (wacc[p]) mem[waddr[p]] <= wdata[p];
      if (clr_we) mem[clr_addr] <= '0;
    end
  end

  for (genvar r = 0; r < NRD; r++) begin : g_rd
    logic [XLEN-1:0] rd;
    always_comb begin
      rd = '0;
      if ((int'(raddr[r]) < NREGS) && !((ZERO_REG != 0) && (raddr[r] == '0)))
        rd = mem[raddr[r]];
      if ((BYPASS != 0) && idle)
        for (int p = 0; p < NWR; p++)
          if (wacc[p] && (waddr[p] == raddr[r])) rd = wdata[p];
    end
    assign rdata[r] = rd;
  end
endmodule
